relu_maxpool22: RTL and testbench
=================================

// Module: relu_maxpool22
// PURPOSE
//  Downstream of the 5x5x3 convolution unit. Consumes its signed convValue
//  stream in raster order and applies ReLU plus 2x2 stride-2 max-pooling.
//  This is the subsampling stage between LeNet-5 C3 and S4; it produces one
//  pooled value per 2x2 window.
//  One half-row line buffer holds the even-row horizontal maxima.
// PARAMETERS
//  OUT_WIDTH  32  width of signed input samples and of output samples
//  IN_COLS    10  conv feature-map width; must be even, >=2
//  IN_ROWS    10  conv feature-map height; must be even, >=2
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          synchronous active-high reset
//  in_valid    in   1          in_data is valid this cycle (no backpressure)
//  in_data     in   OUT_WIDTH  signed conv sample, raster order, row-major
//  out_valid   out  1          out_data is valid this cycle (single-cycle pulse)
//  out_data    out  OUT_WIDTH  pooled, ReLU'd value (always >=0, signed type)
//  out_last    out  1          high with the final pooled value of a frame
//  busy        out  1          high when a frame is partially received
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_last=0, busy=0, col=0, row=0.
//    Line-buffer contents are don't-care after reset.
//  - Reset mid-frame discards the partial frame. The next valid sample is
//    treated as (row 0, col 0).
//  - Counters col (0..IN_COLS-1) and row (0..IN_ROWS-1) advance only on
//    in_valid. Gaps of any length between samples are legal.
//  - Col wraps to 0 and row increments. After (IN_ROWS-1, IN_COLS-1), both
//    wrap to 0 and the next sample starts a new frame.
//  - hold register: on even col, hold <= in_data.
//    On odd col, hmax = max(hold, in_data), compared signed.
//  - Even row, odd col: linebuf[col>>1] <= hmax. No output.
//  - Odd row, odd col: pmax = max(linebuf[col>>1], hmax), compared signed.
//    On the next cycle, out_valid=1 and out_data = (pmax<0) ? 0 : pmax.
//  - Latency: exactly 1 clk from the accepting edge of the window's 4th
//    sample (odd row, odd col) to out_valid. That is, out_valid is
//    registered at the same edge that accepts the 4th sample.
//  - out_last=1 in the same cycle as out_valid for window
//    (IN_ROWS/2-1, IN_COLS/2-1); 0 otherwise.
//  - Outputs per frame: (IN_ROWS/2)*(IN_COLS/2), in raster order of the
//    pooled map.
//  - out_data holds its last value when out_valid=0. out_valid is never high
//    for two windows in one cycle. Back-to-back windows give out_valid
//    every 2 cycles at full input rate.
//  - busy: set on the first accepted sample of a frame. Cleared at the edge
//    accepting the frame's last sample.
//  - Ties: either operand may be chosen; the values are equal.
//  - Most-negative values are compared correctly; no arithmetic, no overflow.
//  - Elaboration: odd IN_COLS or IN_ROWS is a configuration error. Flag it
//    with an initial $error; it is not synthesised behaviour.
// TESTING
//  1 Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, out_data=0,
//    busy=0 throughout.
//  2 Ramp 4x4 (IN_COLS=IN_ROWS=4), in_data=0..15 contiguous
//    -> outputs 5, 7, 13, 15; out_last only on 15; each output 1 cycle after
//    its sample 5/7/13/15.
//  3 All-negative 4x4 frame (-1..-16) -> four outputs of 0; out_last on the
//    fourth.
//  4 Signed extremes: window {-2^31, 3, -7, 2^31-1} -> 2^31-1;
//    window {-2^31, -2^31, -1, -5} -> 0.
//  5 Random gaps: 10x10 frame, in_valid randomly low ~50% -> 25 outputs
//    matching the reference model, in order; none lost or duplicated.
//  6 Reset mid-frame after 23 samples, then a full 10x10 ramp -> exactly 25
//    outputs, all correct for the new frame only; busy low after reset.

Source files
------------

// File: rtl/relu_maxpool22.sv
// ReLU + 2x2 stride-2 max-pooling over a raster-order signed sample stream.
// Even-row horizontal pair maxima wait in a half-row line buffer for the odd row.
module relu_maxpool22 #(
    parameter int OUT_WIDTH = 32,
    parameter int IN_COLS   = 10,
    parameter int IN_ROWS   = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [OUT_WIDTH-1:0] in_data,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        busy
);

    localparam int HALF = IN_COLS / 2;
    localparam int CW   = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
    localparam int RW   = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

    if ((IN_COLS % 2) != 0) begin : g_bad_cols
        $error("relu_maxpool22: IN_COLS must be even");
    end
    if ((IN_ROWS % 2) != 0) begin : g_bad_rows
        $error("relu_maxpool22: IN_ROWS must be even");
    end

    logic        [CW-1:0]        r_col;
    logic        [RW-1:0]        r_row;
    logic signed [OUT_WIDTH-1:0] r_hold;
    logic signed [OUT_WIDTH-1:0] r_linebuf [HALF];
    logic                        r_out_valid;
    logic signed [OUT_WIDTH-1:0] r_out_data;
    logic                        r_out_last;
    logic                        r_busy;

    logic        [HW-1:0]        w_idx;
    logic                        w_last_col;
    logic                        w_last_row;
    logic signed [OUT_WIDTH-1:0] w_line;
    logic signed [OUT_WIDTH-1:0] w_hmax;
    logic signed [OUT_WIDTH-1:0] w_pmax;

    assign w_idx      = HW'(r_col >> 1);
    assign w_last_col = (r_col == CW'(IN_COLS - 1));
    assign w_last_row = (r_row == RW'(IN_ROWS - 1));
    assign w_line     = r_linebuf[w_idx];
    assign w_hmax     = (r_hold > in_data) ? r_hold : in_data;
    assign w_pmax     = (w_line > w_hmax) ? w_line : w_hmax;

    // Raster position, busy flag and the registered pooled output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_hold      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (in_valid) begin
                if (!r_col[0]) begin
                    r_hold <= in_data;
                end else if (r_row[0]) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_pmax[OUT_WIDTH-1] ? '0 : w_pmax;
                    r_out_last  <= w_last_col && w_last_row;
                end
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                r_busy <= !(w_last_col && w_last_row);
            end
        end
    end

    // Line buffer needs no reset: every entry is rewritten by an even row before use.
    always_ff @(posedge clk) begin
        if (!rst && in_valid && r_col[0] && !r_row[0]) begin
            r_linebuf[w_idx] <= w_hmax;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_relu_maxpool22.sv
// Bench for relu_maxpool22: a 4x4 instance driven from a vector table and a
// 10x10 instance driven with random gaps and a mid-frame reset.
module tb_relu_maxpool22;

    localparam int W = 32;

    typedef struct packed {
        logic [0:15][W-1:0] pix;
        logic [0:3][W-1:0]  exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid4 = 1'b0;
    logic                in_valid10 = 1'b0;
    logic signed [W-1:0] in_data4 = '0;
    logic signed [W-1:0] in_data10 = '0;
    logic                out_valid4, out_valid10;
    logic signed [W-1:0] out_data4, out_data10;
    logic                out_last4, out_last10;
    logic                busy4, busy10;

    relu_maxpool22 #(.OUT_WIDTH(W), .IN_COLS(4), .IN_ROWS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4),
        .out_valid(out_valid4), .out_data(out_data4), .out_last(out_last4), .busy(busy4)
    );

    relu_maxpool22 #(.OUT_WIDTH(W), .IN_COLS(10), .IN_ROWS(10)) dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid10), .in_data(in_data10),
        .out_valid(out_valid10), .out_data(out_data10), .out_last(out_last10), .busy(busy10)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: {last, data} plus the negedge cycle it must appear on
    logic [W:0] exp4_q[$];
    logic [W:0] exp10_q[$];
    int         cyc4_q[$];
    int         cyc10_q[$];
    int         n_vec = 0;
    int         n_fail = 0;
    int         frame[100];
    int         exp_win[25];
    logic [W:0] e4, e10;
    int         c4, c10;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid4) begin
            if (exp4_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL dut4 unexpected output: got %0d, required none", out_data4);
            end else begin
                e4 = exp4_q.pop_front();
                c4 = cyc4_q.pop_front();
                check("dut4 data", out_data4, e4[W-1:0]);
                check("dut4 last", W'(out_last4), W'(e4[W]));
                check("dut4 latency", cyc, c4);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid10) begin
            if (exp10_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL dut10 unexpected output: got %0d, required none", out_data10);
            end else begin
                e10 = exp10_q.pop_front();
                c10 = cyc10_q.pop_front();
                check("dut10 data", out_data10, e10[W-1:0]);
                check("dut10 last", W'(out_last10), W'(e10[W]));
                check("dut10 latency", cyc, c10);
            end
        end
    end

    // driver tasks
    task automatic set_in(input bit big, input logic v, input logic [W-1:0] d);
        if (big) begin
            in_valid10 = v;
            in_data10  = d;
        end else begin
            in_valid4 = v;
            in_data4  = d;
        end
    endtask

    task automatic push(input bit big, input int d, input bit last, input int cc);
        if (big) begin
            exp10_q.push_back({last, d});
            cyc10_q.push_back(cc);
        end else begin
            exp4_q.push_back({last, d});
            cyc4_q.push_back(cc);
        end
    endtask

    // Reference: relu(max of the four pixels of window (wr, wc)).
    function automatic int win_max(input int cols, input int wr, input int wc);
        int b;
        int m;
        b = 2 * wr * cols + 2 * wc;
        m = frame[b];
        if (frame[b + 1] > m) m = frame[b + 1];
        if (frame[b + cols] > m) m = frame[b + cols];
        if (frame[b + cols + 1] > m) m = frame[b + cols + 1];
        return (m < 0) ? 0 : m;
    endfunction

    task automatic fill_model(input int rows, input int cols);
        for (int wr = 0; wr < rows / 2; wr++)
            for (int wc = 0; wc < cols / 2; wc++)
                exp_win[wr * (cols / 2) + wc] = win_max(cols, wr, wc);
    endtask

    task automatic drive_frame(input bit big, input int rows, input int cols,
                               input int gap_pct, input int nsamp);
        for (int i = 0; i < nsamp; i++) begin
            int r;
            int c;
            int wi;
            r = i / cols;
            c = i % cols;
            while (int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk);
                set_in(big, 1'b0, '0);
            end
            @(negedge clk);
            set_in(big, 1'b1, frame[i]);
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                wi = (r / 2) * (cols / 2) + c / 2;
                push(big, exp_win[wi], wi == (rows / 2) * (cols / 2) - 1, cyc + 1);
            end
        end
        @(negedge clk);
        set_in(big, 1'b0, '0);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        vec_t vecs[4];
        vecs[0].pix = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        vecs[0].exp = '{5, 7, 13, 15};
        vecs[1].pix = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10, -11, -12, -13, -14, -15, -16};
        vecs[1].exp = '{0, 0, 0, 0};
        vecs[2].pix = '{32'h80000000, 3, 32'h80000000, 32'h80000000,
                        -7, 32'h7fffffff, -1, -5,
                        100, -100, 0, 0,
                        7, 6, 0, 0};
        vecs[2].exp = '{32'h7fffffff, 0, 100, 0};
        vecs[3].pix = '{9, -3, -4, 8, 1, 2, 3, -9, -20, -30, -25, -21, -40, -22, 50, -50};
        vecs[3].exp = '{9, 8, 0, 50};

        // reset held with in_valid high
        in_valid4  = 1'b1;
        in_data4   = 32'h1234;
        in_valid10 = 1'b1;
        in_data10  = 32'h5678;
        repeat (3) begin
            @(negedge clk);
            check("reset out_valid", W'(out_valid4), '0);
            check("reset out_data", out_data4, '0);
            check("reset busy", W'(busy4), '0);
            check("reset busy10", W'(busy10), '0);
        end
        rst        = 1'b0;
        in_valid4  = 1'b0;
        in_valid10 = 1'b0;

        // 4x4 table: ramp, all-negative, signed extremes, mixed (with gaps)
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 16; i++) frame[i] = vecs[v].pix[i];
            for (int j = 0; j < 4; j++) exp_win[j] = vecs[v].exp[j];
            drive_frame(1'b0, 4, 4, (v == 3) ? 40 : 0, 16);
            check("dut4 busy after frame", W'(busy4), '0);
        end

        // 10x10 random data with ~50% gaps
        for (int i = 0; i < 100; i++) frame[i] = $urandom;
        fill_model(10, 10);
        drive_frame(1'b1, 10, 10, 50, 100);
        check("dut10 busy after frame", W'(busy10), '0);

        // partial frame of 23 samples, then reset, then a full ramp
        for (int i = 0; i < 100; i++) frame[i] = 1000 + i * 37;
        fill_model(10, 10);
        drive_frame(1'b1, 10, 10, 0, 23);
        check("dut10 busy mid-frame", W'(busy10), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset busy", W'(busy10), '0);
        check("midreset out_valid", W'(out_valid10), '0);
        check("midreset out_data", out_data10, '0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) frame[i] = i;
        fill_model(10, 10);
        drive_frame(1'b1, 10, 10, 0, 100);
        check("dut10 busy after ramp", W'(busy10), '0);

        for (int k = 0; k < 50 && (exp4_q.size() != 0 || exp10_q.size() != 0); k++)
            @(negedge clk);
        check("outputs outstanding", W'(exp4_q.size() + exp10_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
